// File: rtl/key_event_decoder_pkg.sv
// key_evt_pkg: shared types and helpers for the key event decoder.
//   key_state_t   - classifier state encoding
//   MS_CNT_W      - width of the millisecond counters
//   ticks_per_ms  - sys_clk cycles per millisecond for a given clock frequency
package key_evt_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } key_state_t;

  localparam int unsigned MS_CNT_W = 16;

  function automatic int unsigned ticks_per_ms(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler.
// Counts 0..TICKS_PER_MS-1 and flags tick while the count sits at its
// terminal value, so the consumer sees exactly one tick cycle per ms.
// Ports:
//   sys_clk  in   system clock
//   sys_rst  in   synchronous active-high reset
//   clr      in   synchronous clear, restarts the current millisecond
//   tick     out  one cycle per TICKS_PER_MS cycles
module ms_tick_gen #(
  parameter int unsigned TICKS_PER_MS = 100_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PW-1:0] presc;

  always_comb begin
    tick = (presc == PW'(TICKS_PER_MS - 1));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key presses into short press,
// long press and double click (one-cycle pulses) plus a held level.
// Optional build macro KEY_REPEAT_EN: long_press repeats every REPEAT_MS
// while the key stays in the long-held state.
// Ports:
//   sys_clk       in   system clock
//   sys_rst       in   synchronous active-high reset
//   key_flag      in   strobe: debounced level updated
//   key_value     in   debounced level, valid with key_flag (0 = pressed)
//   short_press   out  pulse: single short press completed
//   long_press    out  pulse: key held for LONG_MS (and repeats if enabled)
//   double_click  out  pulse: second short press released
//   key_held      out  level: key considered pressed
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_flag,
  input  logic key_value,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_held
);

  localparam int unsigned TICKS = ticks_per_ms(CLK_FREQ);

  if ((CLK_FREQ % 1000) != 0 || CLK_FREQ == 0 ||
      LONG_MS   < 1 || LONG_MS   > 65535 ||
      DCLICK_MS < 1 || DCLICK_MS > 65535 ||
      REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_cfg
    $error("key_event_decoder: parameter out of range");
  end

  key_state_t          state, state_nxt;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                ms_tick;
  logic                state_chg;
  logic                press_ev, rel_ev;
  logic                sp_nxt, lp_nxt, dc_nxt, held_nxt;

  always_comb begin
    press_ev  = key_flag & ~key_value;
    rel_ev    = key_flag & key_value;
    state_chg = (state_nxt != state);
  end

  // Timing restarts on every transition; redundant events leave state
  // unchanged and therefore do not disturb the running count.
  ms_tick_gen #(
    .TICKS_PER_MS(TICKS)
  ) u_ms_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (state_chg),
    .tick    (ms_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_chg) begin
      ms_cnt <= '0;
    end else if (ms_tick && (ms_cnt != '1)) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  // Fires on the tick that completes REPEAT_MS, so repeats are exactly
  // REPEAT_MS apart starting from LONG_HELD entry.
  logic [MS_CNT_W-1:0] rep_cnt;
  logic                rep_fire;

  always_comb begin
    rep_fire = ms_tick && (rep_cnt == MS_CNT_W'(REPEAT_MS - 1));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_chg) begin
      rep_cnt <= '0;
    end else if (ms_tick) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    sp_nxt    = 1'b0;
    lp_nxt    = 1'b0;
    dc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (press_ev) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_nxt = WAIT2;
        end else if (ms_cnt == MS_CNT_W'(LONG_MS)) begin
          state_nxt = LONG_HELD;
          lp_nxt    = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_nxt = PRESS2;
        end else if (ms_cnt == MS_CNT_W'(DCLICK_MS)) begin
          state_nxt = IDLE;
          sp_nxt    = 1'b1;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          state_nxt = IDLE;
          dc_nxt    = 1'b1;
        end else if (ms_cnt == MS_CNT_W'(LONG_MS)) begin
          state_nxt = LONG_HELD;
          lp_nxt    = 1'b1;
        end
      end
      LONG_HELD: begin
        if (rel_ev) begin
          state_nxt = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_fire) begin
          lp_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    held_nxt = (state_nxt == PRESS1) || (state_nxt == PRESS2) ||
               (state_nxt == LONG_HELD);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_nxt;
      short_press  <= sp_nxt;
      long_press   <= lp_nxt;
      double_click <= dc_nxt;
      key_held     <= held_nxt;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder at 10 cycles/ms
// (LONG_MS=50, DCLICK_MS=20, REPEAT_MS=10).
// Cycle bookkeeping: cyc counts rising edges. A strobe sampled at edge N
// changes state at N; a timeout whose condition holds in cycle N-1 makes
// its pulse visible in cycle N. With 10 cycles/ms, ms_cnt reaches M in
// cycle start+10*M, so a timeout pulse lands 10*M+1 edges after the
// transition that started the count.
module tb_key_event_decoder;

  localparam int unsigned CLK_FREQ  = 10_000;
  localparam int unsigned LONG_MS   = 50;
  localparam int unsigned DCLICK_MS = 20;
  localparam int unsigned REPEAT_MS = 10;

`ifdef KEY_REPEAT_EN
  localparam int LONG_PULSES = 3;    // at +501, +601, +701 within an 800-cycle hold
  localparam int LONG_LAST   = 701;
`else
  localparam int LONG_PULSES = 1;
  localparam int LONG_LAST   = 501;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_value = 1'b1;
  logic short_press, long_press, double_click, key_held;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sp_cnt = 0, lp_cnt = 0, dc_cnt = 0, excl_cnt = 0;
  int sp_cyc = 0, lp_cyc = 0, dc_cyc = 0;
  int b_sp, b_lp, b_dc, t0, tr;

  key_event_decoder #(
    .CLK_FREQ (CLK_FREQ),
    .LONG_MS  (LONG_MS),
    .DCLICK_MS(DCLICK_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .key_held    (key_held)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (short_press  === 1'b1) begin sp_cnt++; sp_cyc = cyc; end
    if (long_press   === 1'b1) begin lp_cnt++; lp_cyc = cyc; end
    if (double_click === 1'b1) begin dc_cnt++; dc_cyc = cyc; end
    if ((32'(short_press) + 32'(long_press) + 32'(double_click)) > 1) excl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One strobe, sampled at the next rising edge; the level is then driven
  // to the opposite value to show it is ignored without key_flag.
  task automatic key_ev(input logic v);
    key_flag  = 1'b1;
    key_value = v;
    step(1);
    key_flag  = 1'b0;
    key_value = ~v;
  endtask

  task automatic snap();
    b_sp = sp_cnt;
    b_lp = lp_cnt;
    b_dc = dc_cnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(3);
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_dclick", double_click, 0);
    check("rst_held", key_held, 0);
    sys_rst = 1'b0;
    step(2);

    // Release strobe in IDLE is ignored
    snap();
    key_ev(1'b1);
    step(2);
    check("idle_rel_held", key_held, 0);

    // Short press: hold 10 ms, short_press 201 edges after release
    snap();
    key_ev(1'b0);
    check("short_held_on", key_held, 1);
    step(99);
    key_ev(1'b1);
    tr = cyc;
    check("short_held_off", key_held, 0);
    step(250);
    check("short_cnt", sp_cnt - b_sp, 1);
    check("short_lat", sp_cyc - tr, 201);
    check("short_no_long", lp_cnt - b_lp, 0);
    check("short_no_dc", dc_cnt - b_dc, 0);

    // Long press with redundant press strobes: timing still from first press
    snap();
    key_ev(1'b0);
    t0 = cyc;
    step(99);
    key_ev(1'b0);
    step(99);
    key_ev(1'b0);
    step(600);
    check("long_held", key_held, 1);
    check("long_cnt", lp_cnt - b_lp, LONG_PULSES);
    check("long_lat", lp_cyc - t0, LONG_LAST);
    key_ev(1'b1);
    step(5);
    check("long_rel_held", key_held, 0);
    step(300);
    check("long_rel_cnt", lp_cnt - b_lp, LONG_PULSES);
    check("long_no_short", sp_cnt - b_sp, 0);
    check("long_no_dc", dc_cnt - b_dc, 0);

    // Double click: 5 ms press, 10 ms gap, 5 ms press
    snap();
    key_ev(1'b0);
    step(49);
    key_ev(1'b1);
    step(99);
    key_ev(1'b0);
    check("dc_held2", key_held, 1);
    step(49);
    key_ev(1'b1);
    tr = cyc;
    check("dc_pulse_now", double_click, 1);
    step(300);
    check("dc_cnt", dc_cnt - b_dc, 1);
    check("dc_lat", dc_cyc - tr, 0);
    check("dc_no_short", sp_cnt - b_sp, 0);
    check("dc_no_long", lp_cnt - b_lp, 0);

    // Release in the exact cycle ms_cnt==LONG_MS: release wins
    snap();
    key_ev(1'b0);
    step(99);
    key_ev(1'b0);
    step(99);
    key_ev(1'b0);
    step(300);
    key_ev(1'b1);
    tr = cyc;
    check("prio_held", key_held, 0);
    step(250);
    check("prio_no_long", lp_cnt - b_lp, 0);
    check("prio_short_cnt", sp_cnt - b_sp, 1);
    check("prio_short_lat", sp_cyc - tr, 201);

    // Reset during WAIT2 discards the pending short press
    snap();
    key_ev(1'b0);
    step(49);
    key_ev(1'b1);
    step(50);
    sys_rst = 1'b1;
    step(1);
    check("rstw_short", short_press, 0);
    check("rstw_long", long_press, 0);
    check("rstw_dclick", double_click, 0);
    check("rstw_held", key_held, 0);
    step(2);
    sys_rst = 1'b0;
    step(400);
    check("rstw_no_short", sp_cnt - b_sp, 0);

    // Reset during PRESS1 drops key_held and discards the long timeout
    snap();
    key_ev(1'b0);
    step(10);
    check("rstp_held_on", key_held, 1);
    sys_rst = 1'b1;
    step(1);
    check("rstp_held_off", key_held, 0);
    sys_rst = 1'b0;
    step(600);
    check("rstp_no_long", lp_cnt - b_lp, 0);
    check("rstp_no_short", sp_cnt - b_sp, 0);

    check("exclusive", excl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumer of the debounced key interface (key_flag strobe plus key_value level, active-low press).
- Classifies each debounced key press into a short press, long press or double click, each reported as a one-cycle pulse, plus a held level.
- Sits between the debouncer and the ranging control logic; e.g. a short press triggers a single measurement, a long press toggles continuous mode.

Parameters:
- CLK_FREQ, 100_000_000, sys_clk frequency in Hz; must be a multiple of 1000.
- LONG_MS, 1000, press duration in ms that qualifies as a long press; range 1..65535.
- DCLICK_MS, 300, max gap in ms from first release to second press for a double click; range 1..65535.
- REPEAT_MS, 200, auto-repeat period in ms; used only when the optional feature is enabled.

Ports:
- sys_clk  input  1  system clock; the only clock.
- sys_rst  input  1  synchronous, active-high reset.
- key_flag  input  1  one-cycle strobe: debounced key level has been updated.
- key_value  input  1  debounced key level, valid when key_flag=1; 0=pressed, 1=released.
- short_press  output  1  one-cycle pulse: single short press completed.
- long_press  output  1  one-cycle pulse: press held for LONG_MS.
- double_click  output  1  one-cycle pulse: second short press released.
- key_held  output  1  level: key currently considered pressed.

Behaviour:
- Clocking and reset: one clock, sys_clk; reset sys_rst is synchronous and active-high. While sys_rst=1, state=IDLE, counters=0, all outputs=0. Reset mid-sequence discards the sequence; no pulse is emitted.
- Events: press_ev = key_flag & ~key_value; rel_ev = key_flag & key_value. key_value is ignored when key_flag=0.
- ms tick: prescaler counts 0..CLK_FREQ/1000-1 and pulses tick on wrap. Prescaler and the 16-bit ms counter both clear on every state transition. ms counter increments on tick and saturates at 16'hFFFF.
- State IDLE:
  - press_ev -> PRESS1.
  - rel_ev is ignored.
- State PRESS1:
  - rel_ev -> WAIT2.
  - else if ms_cnt==LONG_MS -> LONG_HELD, pulse long_press.
- State WAIT2:
  - press_ev -> PRESS2.
  - else if ms_cnt==DCLICK_MS -> IDLE, pulse short_press.
- State PRESS2:
  - rel_ev -> IDLE, pulse double_click.
  - else if ms_cnt==LONG_MS -> LONG_HELD, pulse long_press. The first click is discarded.
- State LONG_HELD:
  - rel_ev -> IDLE, no pulse.
- Priority: a key event wins over a timeout in the same cycle. A redundant event (press_ev in a press state, rel_ev in IDLE/WAIT2) is ignored and does not clear the counters.
- Output timing: all outputs are registered. A pulse is high for exactly one cycle, in the cycle after the triggering event or timeout.
- Output exclusivity: at most one of short_press, long_press, double_click is high in any cycle.
- key_held=1 while state is PRESS1, PRESS2 or LONG_HELD. It updates in the same cycle as the state register.
- Latency: short_press is reported DCLICK_MS after release (deliberate, so double clicks can be disambiguated).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in LONG_HELD, long_press pulses again every REPEAT_MS. The repeat counter starts at LONG_HELD entry, so the first repeat comes REPEAT_MS after the initial pulse. Repeats stop immediately on rel_ev.
- Undefined: long_press pulses exactly once per hold. No repeat counter logic exists.

Decomposition:
- Package key_evt_pkg: state enum (IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD), MS_CNT_W=16, and a function computing ticks-per-ms from CLK_FREQ.
- Natural sub-module: ms_tick_gen (prescaler with synchronous clear input, tick output), instantiated once.

Test Plan (CLK_FREQ=10_000, i.e. 10 cycles/ms; LONG_MS=50, DCLICK_MS=20, REPEAT_MS=10):
- Short press: press, release after 10 ms -> short_press single pulse 20 ms (≈200 cycles) after the release strobe; long_press and double_click stay 0.
- Long press: press, hold 80 ms -> long_press single pulse 500 cycles after the press strobe; key_held=1 until release; release -> no pulse.
- Double click: press 5 ms, gap 10 ms, press 5 ms, release -> double_click pulse one cycle after the second release; short_press never asserted.
- Same-cycle priority: release strobe in exactly the cycle ms_cnt reaches 50 in PRESS1 -> state WAIT2, no long_press; redundant press strobes in PRESS1 -> ignored, timing unchanged.
- Reset mid-sequence: sys_rst=1 during WAIT2 -> all outputs 0 next cycle; no short_press after reset release.
- KEY_REPEAT_EN defined: hold 100 ms -> long_press pulses at 50, 60, 70, 80, 90 ms after press; none after release.
